// File: rtl/mem_lsu_pkg.sv
// +------------------------------------------------------------------+
// | mem_lsu_pkg                                                      |
// | Shared funct3 codes, FSM encodings and op legality for mem_lsu.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

package mem_lsu_pkg;

    localparam logic [2:0] c_LSU_B  = 3'b000;
    localparam logic [2:0] c_LSU_H  = 3'b001;
    localparam logic [2:0] c_LSU_W  = 3'b010;
    localparam logic [2:0] c_LSU_BU = 3'b100;
    localparam logic [2:0] c_LSU_HU = 3'b101;

    localparam logic [0:0] c_LSU_IDLE = 1'b0;
    localparam logic [0:0] c_LSU_BUS  = 1'b1;

    localparam int c_STRB_W = 4;

    // Unsigned variants only make sense for loads.
    function automatic logic op_illegal(input logic [2:0] op, input logic is_store);
        logic r;
        case (op)
            c_LSU_B, c_LSU_H, c_LSU_W: r = 1'b0;
            c_LSU_BU, c_LSU_HU:        r = is_store;
            default:                   r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lsu_align.sv
// +------------------------------------------------------------------+
// | mem_lsu_align                                                    |
// | Store lane replication/strobes, load extract/extend, misalign.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module mem_lsu_align
    import mem_lsu_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [2:0]          i_op,
    input  logic [1:0]          i_offset,
    input  logic                i_is_store,
    input  logic [DW-1:0]       i_wdata,
    input  logic [DW-1:0]       i_rdata,
    output logic [DW-1:0]       o_st_data,
    output logic [c_STRB_W-1:0] o_st_strb,
    output logic [DW-1:0]       o_ld_data,
    output logic                o_misalign
);

    logic [DW-1:0] w_shifted;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;

    assign w_shifted = i_rdata >> {i_offset, 3'b000};
    assign w_byte    = w_shifted[7:0];
    assign w_half    = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_st_data = i_wdata;
        o_st_strb = 4'b1111;
        case (i_op[1:0])
            2'b00: begin
                o_st_data = {4{i_wdata[7:0]}};
                o_st_strb = 4'b0001 << i_offset;
            end
            2'b01: begin
                o_st_data = {2{i_wdata[15:0]}};
                o_st_strb = 4'b0011 << {i_offset[1], 1'b0};
            end
            default: ;
        endcase
    end

    always_comb begin
        o_ld_data = i_rdata;
        case (i_op)
            c_LSU_B:  o_ld_data = {{24{w_byte[7]}}, w_byte};
            c_LSU_H:  o_ld_data = {{16{w_half[15]}}, w_half};
            c_LSU_BU: o_ld_data = {24'd0, w_byte};
            c_LSU_HU: o_ld_data = {16'd0, w_half};
            default:  ;
        endcase
    end

    assign o_misalign = op_illegal(i_op, i_is_store)
                      | ((i_op[1:0] == 2'b01) & i_offset[0])
                      | ((i_op[1:0] == 2'b10) & (|i_offset));

endmodule

`default_nettype wire

// File: rtl/mem_lsu.sv
// +------------------------------------------------------------------+
// | mem_lsu                                                          |
// | Load/store stage: single-outstanding bus access and writeback.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                valid_i,
    input  logic                mem_rd,
    input  logic                mem_wr,
    input  logic [2:0]          mem_op,
    input  logic [AW-1:0]       addr_i,
    input  logic [DW-1:0]       wdata_i,
    input  logic [4:0]          rd_addr_i,
    input  logic                rd_we_i,
    output logic                bus_req,
    output logic                bus_we,
    output logic [AW-1:0]       bus_addr,
    output logic [c_STRB_W-1:0] bus_wstrb,
    output logic [DW-1:0]       bus_wdata,
    input  logic                bus_ack,
    input  logic [DW-1:0]       bus_rdata,
    input  logic                bus_err,
    output logic                hold,
    output logic                wb_valid,
    output logic                wb_we,
    output logic [4:0]          wb_rd,
    output logic [DW-1:0]       wb_data,
    output logic                exc_misalign,
    output logic                exc_bus
);

    logic [0:0]    r_state;
    logic [2:0]    r_op;
    logic [1:0]    r_off;
    logic [4:0]    r_rd;
    logic          r_load;

    // Instruction captured in the ack cycle, issued on the following cycle.
    logic          r_pend;
    logic          r_p_rd;
    logic          r_p_wr;
    logic [2:0]    r_p_op;
    logic [AW-1:0] r_p_addr;
    logic [DW-1:0] r_p_wdata;
    logic [4:0]    r_p_rd_addr;
    logic          r_p_rd_we;

    logic          w_busy;
    logic          w_valid;
    logic          w_mem_rd;
    logic          w_mem_wr;
    logic [2:0]    w_mem_op;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;
    logic [4:0]    w_rd_addr;
    logic          w_rd_we;
    logic          w_mem;
    logic          w_load;
    logic          w_issue;
    logic [2:0]    w_al_op;
    logic [1:0]    w_al_off;
    logic [DW-1:0] w_st_data;
    logic [3:0]    w_st_strb;
    logic [DW-1:0] w_ld_data;
    logic          w_misalign;

    assign w_busy    = (r_state == c_LSU_BUS);
    assign w_valid   = r_pend | valid_i;
    assign w_mem_rd  = r_pend ? r_p_rd      : mem_rd;
    assign w_mem_wr  = r_pend ? r_p_wr      : mem_wr;
    assign w_mem_op  = r_pend ? r_p_op      : mem_op;
    assign w_addr    = r_pend ? r_p_addr    : addr_i;
    assign w_wdata   = r_pend ? r_p_wdata   : wdata_i;
    assign w_rd_addr = r_pend ? r_p_rd_addr : rd_addr_i;
    assign w_rd_we   = r_pend ? r_p_rd_we   : rd_we_i;

    assign w_mem  = w_mem_rd | w_mem_wr;
    assign w_load = w_mem_rd & ~w_mem_wr;

    assign w_al_op  = w_busy ? r_op  : w_mem_op;
    assign w_al_off = w_busy ? r_off : w_addr[1:0];

    mem_lsu_align #(
        .DW (DW)
    ) u_align (
        .i_op       (w_al_op),
        .i_offset   (w_al_off),
        .i_is_store (w_mem_wr),
        .i_wdata    (w_wdata),
        .i_rdata    (bus_rdata),
        .o_st_data  (w_st_data),
        .o_st_strb  (w_st_strb),
        .o_ld_data  (w_ld_data),
        .o_misalign (w_misalign)
    );

    assign w_issue = ~w_busy & w_valid & w_mem & ~w_misalign;

    // A pending instruction occupies the stage, so the live one must wait.
    assign hold = rstn & (w_busy ? ~bus_ack : (w_issue | r_pend));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= c_LSU_IDLE;
            r_op         <= 3'd0;
            r_off        <= 2'd0;
            r_rd         <= 5'd0;
            r_load       <= 1'b0;
            r_pend       <= 1'b0;
            r_p_rd       <= 1'b0;
            r_p_wr       <= 1'b0;
            r_p_op       <= 3'd0;
            r_p_addr     <= '0;
            r_p_wdata    <= '0;
            r_p_rd_addr  <= 5'd0;
            r_p_rd_we    <= 1'b0;
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_addr     <= '0;
            bus_wstrb    <= '0;
            bus_wdata    <= '0;
            wb_valid     <= 1'b0;
            wb_we        <= 1'b0;
            wb_rd        <= 5'd0;
            wb_data      <= '0;
            exc_misalign <= 1'b0;
            exc_bus      <= 1'b0;
        end else begin
            wb_valid     <= 1'b0;
            wb_we        <= 1'b0;
            exc_misalign <= 1'b0;
            exc_bus      <= 1'b0;
            case (r_state)
                c_LSU_IDLE: begin
                    r_pend <= 1'b0;
                    if (w_valid) begin
                        if (!w_mem) begin
                            wb_valid <= 1'b1;
                            wb_we    <= w_rd_we;
                            wb_rd    <= w_rd_addr;
                            wb_data  <= DW'(w_addr);
                        end else if (w_misalign) begin
                            wb_valid     <= 1'b1;
                            exc_misalign <= 1'b1;
                            wb_rd        <= w_rd_addr;
                            wb_data      <= DW'(w_addr);
                        end else begin
                            bus_req   <= 1'b1;
                            bus_we    <= w_mem_wr;
                            bus_addr  <= {w_addr[AW-1:2], 2'b00};
                            bus_wstrb <= w_mem_wr ? w_st_strb : 4'b0000;
                            bus_wdata <= w_mem_wr ? w_st_data : '0;
                            r_op      <= w_mem_op;
                            r_off     <= w_addr[1:0];
                            r_rd      <= w_rd_addr;
                            r_load    <= w_load;
                            r_state   <= c_LSU_BUS;
                        end
                    end
                end
                default: begin
                    if (bus_ack) begin
                        bus_req     <= 1'b0;
                        wb_valid    <= 1'b1;
                        wb_we       <= r_load & ~bus_err;
                        wb_rd       <= r_rd;
                        wb_data     <= r_load ? w_ld_data : '0;
                        exc_bus     <= bus_err;
                        r_state     <= c_LSU_IDLE;
                        r_pend      <= valid_i;
                        r_p_rd      <= mem_rd;
                        r_p_wr      <= mem_wr;
                        r_p_op      <= mem_op;
                        r_p_addr    <= addr_i;
                        r_p_wdata   <= wdata_i;
                        r_p_rd_addr <= rd_addr_i;
                        r_p_rd_we   <= rd_we_i;
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire
